phase_seq: RTL and testbench
============================

Name: phase_seq

Overview:
- Parametrised successor to the free-running one-hot 5-phase clock ring that drives the fetch, decode, execute, memory and writeback stages.
- It produces one-hot phase enables on a single clock domain instead of derived clocks.
- Adds per-phase stall, halt at instruction boundary, single-step and a retired-instruction counter.
- Sits at the top level and feeds the PC, register, ALU, memory and writeback stages with PHASE/ADV qualifiers.

Parameters:
N_PHASES, 5, number of pipeline phases per instruction (>= 2; elaboration error otherwise)
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  input  1  system clock; all state on rising edge
RST_N  input  1  asynchronous active-low reset
RUN_EN  input  1  level; free-run enable
STEP_REQ  input  1  pulse; execute exactly one instruction while halted
HALT_REQ  input  1  pulse or level; request stop at next instruction boundary
STALL  input  1  level; hold current phase, no advance
CNT_CLR  input  1  synchronous clear of RETIRED
PHASE  output  N_PHASES  one-hot active phase; all-zero when halted
ADV  output  1  current phase commits this cycle (= active & !STALL)
HALTED  output  1  sequencer in HALTED state
RETIRED  output  CNT_W  instructions completed, modulo 2^CNT_W
WRAP  output  1  one-cycle pulse when RETIRED wraps to 0

Behaviour:
- Reset (async, RST_N=0):
  - state=HALTED, phase register=bit0, PHASE=0, ADV=0, HALTED=1, RETIRED=0, WRAP=0, halt_pend=0.
  - Reset mid-instruction abandons the instruction with no retire count.
- States: HALTED, RUN, STEP.
- HALTED:
  - RUN_EN=1 -> RUN; PHASE=bit0 on the next cycle.
  - Else STEP_REQ=1 -> STEP.
  - RUN_EN wins if both are asserted.
  - STALL and HALT_REQ have no effect.
- RUN / STEP:
  - PHASE = phase register; ADV = !STALL.
  - On ADV the phase rotates left by one; bit N_PHASES-1 wraps to bit0.
  - STALL=1 holds the phase with ADV=0 for any number of cycles.
- Instruction boundary (last-phase ADV):
  - RETIRED increments.
  - RUN: goes to HALTED if halt_pend | HALT_REQ | !RUN_EN, else continues at bit0 with no bubble.
  - STEP: always goes to HALTED.
  - Entering HALTED clears halt_pend and resets the phase register to bit0.
- halt_pend:
  - Set by HALT_REQ in RUN on any non-boundary cycle; sticky until halt is taken.
  - HALT_REQ in STEP is ignored; the step completes regardless.
- STEP_REQ outside HALTED is ignored and not queued.
- RUN_EN deassertion mid-instruction takes effect only at the boundary; the instruction always completes.
- Throughput: with no stall, one instruction per N_PHASES cycles; each stall cycle adds one cycle.
- Counter:
  - RETIRED rolls from 2^CNT_W-1 to 0; WRAP=1 on the cycle RETIRED reads 0 after rollover (registered with the counter).
  - CNT_CLR has priority over a simultaneous increment (result 0, WRAP=0).
- Robustness: a non-one-hot phase register (SEU) is forced to bit0 on the next cycle without a retire count.
- Outputs PHASE, ADV, HALTED are combinational from registered state and STALL only; there is no path from RUN_EN/STEP_REQ/HALT_REQ to outputs.

Decomposition:
- Shared package phase_seq_pkg:
  - state enum (ST_HALTED, ST_RUN, ST_STEP)
  - one-hot rotate function
  - is_onehot check function
- One natural sub-module: retire_counter (CNT_W param; inc, clr, count, wrap).

Test Plan:
1. Reset then RUN_EN=1 for 20 cycles, N_PHASES=5, STALL=0 -> PHASE cycles 00001,00010,00100,01000,10000 repeatedly; ADV=1 every cycle; RETIRED=4 after cycle 20.
2. STALL=1 for 3 cycles while PHASE=00100 -> PHASE held at 00100, ADV=0 for 3 cycles, instruction takes 8 cycles, RETIRED +1.
3. HALT_REQ single pulse while PHASE=00010 in RUN -> phases 00100..10000 complete, HALTED=1 the cycle after the 10000 ADV, PHASE=0, RETIRED +1.
4. From HALTED, STEP_REQ pulse -> exactly 5 phases then HALTED, RETIRED +1; second STEP_REQ at PHASE=01000 is ignored (RETIRED +1 total only).
5. CNT_W=4, free-run 16 instructions -> RETIRED goes 15->0 with WRAP=1 for one cycle; CNT_CLR together with the increment gives RETIRED=0, WRAP=0.
6. RST_N low asynchronously at PHASE=01000, mid-clock -> PHASE=0, HALTED=1, RETIRED=0 immediately; after release with RUN_EN=1, PHASE=00001 on the next edge.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: shared state encoding and one-hot phase helpers for the phase sequencer.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_RUN,
        ST_STEP
    } state_e;

    localparam int MAX_PH = 32;

    // Rotates the low n bits left by one; bit n-1 wraps to bit0 and bits above n stay clear.
    function automatic logic [MAX_PH-1:0] rot_onehot(input logic [MAX_PH-1:0] v, input int n);
        logic [MAX_PH-1:0] r;
        r = '0;
        r[0] = v[n-1];
        for (int i = 1; i < MAX_PH; i++)
            r[i] = (i < n) ? v[i-1] : 1'b0;
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MAX_PH-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/phase_seq_retire_counter.sv
// retire_counter: retired-instruction counter with synchronous clear and a registered wrap pulse.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        count_d = clr ? '0 : inc ? count_q + 1'b1 : count_q;
        wrap_d  = !clr && inc && (count_q == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/phase_seq.sv
// phase_seq: one-hot N-phase instruction sequencer with stall, boundary halt, single-step
// and a retired-instruction counter.
module phase_seq
    import phase_seq_pkg::*;
#(
    parameter int N_PHASES = 5,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RUN_EN,
    input  logic                STEP_REQ,
    input  logic                HALT_REQ,
    input  logic                STALL,
    input  logic                CNT_CLR,
    output logic [N_PHASES-1:0] PHASE,
    output logic                ADV,
    output logic                HALTED,
    output logic [CNT_W-1:0]    RETIRED,
    output logic                WRAP
);

    if (N_PHASES < 2 || N_PHASES > MAX_PH) begin : g_bad_n_phases
        $error("phase_seq: N_PHASES must be in 2..%0d", MAX_PH);
    end

    localparam logic [N_PHASES-1:0] PH_FIRST = N_PHASES'(1);

    state_e              state_q, state_d;
    logic [N_PHASES-1:0] phase_q, phase_d;
    logic                halt_pend_q, halt_pend_d;
    logic                active, valid, adv, boundary;

    assign active   = (state_q != ST_HALTED);
    assign valid    = is_onehot(MAX_PH'(phase_q));
    assign adv      = active && !STALL;
    // A corrupted phase word never counts as a boundary, so an SEU cannot retire.
    assign boundary = adv && valid && phase_q[N_PHASES-1];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            ST_HALTED: begin
                phase_d     = PH_FIRST;
                halt_pend_d = 1'b0;
                state_d     = RUN_EN ? ST_RUN : STEP_REQ ? ST_STEP : ST_HALTED;
            end
            ST_RUN, ST_STEP: begin
                if (!valid)
                    phase_d = PH_FIRST;
                else if (adv)
                    phase_d = N_PHASES'(rot_onehot(MAX_PH'(phase_q), N_PHASES));
                if (state_q == ST_RUN && HALT_REQ && !boundary)
                    halt_pend_d = 1'b1;
                if (boundary && (state_q == ST_STEP || halt_pend_q || HALT_REQ || !RUN_EN)) begin
                    state_d     = ST_HALTED;
                    phase_d     = PH_FIRST;
                    halt_pend_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_HALTED;
                phase_d     = PH_FIRST;
                halt_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_HALTED;
            phase_q     <= PH_FIRST;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign PHASE  = active ? phase_q : '0;
    assign ADV    = adv;
    assign HALTED = !active;

    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (boundary),
        .clr   (CNT_CLR),
        .count (RETIRED),
        .wrap  (WRAP)
    );

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: table vectors, hand-written corner sequences and a randomized run checked
// against an instruction-level model of the sequencer.
module tb_phase_seq;

    localparam int NP = 5;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          RUN_EN = 1'b0, STEP_REQ = 1'b0, HALT_REQ = 1'b0, STALL = 1'b0, CNT_CLR = 1'b0;
    logic [NP-1:0] PHASE;
    logic          ADV, HALTED, WRAP;
    logic [CW-1:0] RETIRED;

    phase_seq #(.N_PHASES(NP), .CNT_W(CW)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RUN_EN   (RUN_EN),
        .STEP_REQ (STEP_REQ),
        .HALT_REQ (HALT_REQ),
        .STALL    (STALL),
        .CNT_CLR  (CNT_CLR),
        .PHASE    (PHASE),
        .ADV      (ADV),
        .HALTED   (HALTED),
        .RETIRED  (RETIRED),
        .WRAP     (WRAP)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // Instruction-level model: mode 0=halted 1=run 2=step, phase as an index.
    int m_mode, m_p, m_ret;
    bit m_wrap, m_hp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_p = 0; m_ret = 0; m_wrap = 0; m_hp = 0;
    endtask

    task automatic drive(input logic run, step, halt, stall, clr);
        RUN_EN = run; STEP_REQ = step; HALT_REQ = halt; STALL = stall; CNT_CLR = clr;
        #1;
    endtask

    task automatic model_check();
        logic [NP-1:0] ep;
        ep = (m_mode != 0) ? NP'(1 << m_p) : '0;
        chk("model", {20'd0, PHASE, ADV, HALTED, RETIRED, WRAP},
            {20'd0, ep, (m_mode != 0) && !STALL, m_mode == 0, CW'(m_ret), m_wrap});
    endtask

    task automatic edge_update();
        bit done, stop;
        @(posedge CLK);
        done = (m_mode != 0) && !STALL && (m_p == NP - 1);
        m_wrap = 0;
        if (CNT_CLR) m_ret = 0;
        else if (done) begin
            m_ret = (m_ret + 1) % (1 << CW);
            m_wrap = (m_ret == 0);
        end
        if (m_mode == 0) begin
            m_hp = 0; m_p = 0;
            m_mode = RUN_EN ? 1 : STEP_REQ ? 2 : 0;
        end else begin
            if (m_mode == 1 && HALT_REQ && !done) m_hp = 1;
            if (done) begin
                stop = (m_mode == 2) || m_hp || HALT_REQ || !RUN_EN;
                m_p = 0;
                if (stop) begin m_mode = 0; m_hp = 0; end
            end else if (!STALL) m_p = m_p + 1;
        end
        @(negedge CLK);
    endtask

    task automatic cycle(input logic run, step, halt, stall, clr);
        drive(run, step, halt, stall, clr);
        model_check();
        edge_update();
    endtask

    typedef struct {
        logic          run, step, halt, stall;
        logic [NP-1:0] ph;
        logic          adv, hlt;
        logic [CW-1:0] ret;
    } vec_t;

    vec_t vt[23];

    initial begin
        int guard;
        bit saw;
        logic [CW-1:0] prev;

        //         run step halt stall phase     adv hlt ret
        vt[0]  = '{1, 0, 0, 0, 5'b00000, 0, 1, 0};
        vt[1]  = '{1, 0, 0, 0, 5'b00001, 1, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 5'b00010, 1, 0, 0};
        vt[3]  = '{1, 0, 0, 1, 5'b00100, 0, 0, 0};
        vt[4]  = '{1, 0, 0, 1, 5'b00100, 0, 0, 0};
        vt[5]  = '{1, 0, 0, 1, 5'b00100, 0, 0, 0};
        vt[6]  = '{1, 0, 0, 0, 5'b00100, 1, 0, 0};
        vt[7]  = '{1, 0, 0, 0, 5'b01000, 1, 0, 0};
        vt[8]  = '{1, 0, 0, 0, 5'b10000, 1, 0, 0};
        vt[9]  = '{1, 0, 0, 0, 5'b00001, 1, 0, 1};
        vt[10] = '{1, 0, 1, 0, 5'b00010, 1, 0, 1};
        vt[11] = '{1, 0, 0, 0, 5'b00100, 1, 0, 1};
        vt[12] = '{1, 0, 0, 0, 5'b01000, 1, 0, 1};
        vt[13] = '{1, 0, 0, 0, 5'b10000, 1, 0, 1};
        vt[14] = '{0, 0, 0, 0, 5'b00000, 0, 1, 2};
        vt[15] = '{0, 1, 0, 0, 5'b00000, 0, 1, 2};
        vt[16] = '{0, 0, 0, 0, 5'b00001, 1, 0, 2};
        vt[17] = '{0, 0, 0, 0, 5'b00010, 1, 0, 2};
        vt[18] = '{0, 0, 1, 0, 5'b00100, 1, 0, 2};
        vt[19] = '{0, 1, 0, 0, 5'b01000, 1, 0, 2};
        vt[20] = '{0, 0, 0, 0, 5'b10000, 1, 0, 2};
        vt[21] = '{0, 0, 0, 0, 5'b00000, 0, 1, 3};
        vt[22] = '{0, 0, 0, 0, 5'b00000, 0, 1, 3};

        model_reset();
        repeat (2) @(negedge CLK);
        chk("reset_phase", 32'(PHASE), 0);
        chk("reset_halted", 32'(HALTED), 1);
        chk("reset_retired", 32'(RETIRED), 0);
        chk("reset_wrap", 32'(WRAP), 0);
        RST_N = 1'b1;

        // Stall, halt pulse and single-step behaviour from the table.
        for (int i = 0; i < 23; i++) begin
            drive(vt[i].run, vt[i].step, vt[i].halt, vt[i].stall, 1'b0);
            model_check();
            chk($sformatf("vec%0d", i), {19'd0, PHASE, ADV, HALTED, RETIRED},
                {19'd0, vt[i].ph, vt[i].adv, vt[i].hlt, vt[i].ret});
            edge_update();
        end

        // Counter rollover to 0 with a one-cycle WRAP pulse.
        saw = 0;
        for (int i = 0; i < 200 && !saw; i++) begin
            prev = RETIRED;
            cycle(1, 0, 0, 0, 0);
            if (prev == 4'hF && RETIRED == 4'h0) begin
                chk("wrap_pulse", 32'(WRAP), 1);
                saw = 1;
            end
        end
        chk("wrap_seen", 32'(saw), 1);
        cycle(1, 0, 0, 0, 0);
        chk("wrap_clear", 32'(WRAP), 0);

        // Clear coinciding with the increment that would wrap: clear wins, no WRAP.
        guard = 0;
        while (!(m_mode == 1 && m_ret == 15 && m_p == NP - 1) && guard < 200) begin
            cycle(1, 0, 0, 0, 0);
            guard++;
        end
        chk("clr_reach", 32'(guard < 200), 1);
        cycle(1, 0, 0, 0, 1);
        chk("clr_retired", 32'(RETIRED), 0);
        chk("clr_wrap", 32'(WRAP), 0);

        // Asynchronous reset in the middle of an instruction.
        guard = 0;
        while (m_p != 3 && guard < 20) begin
            cycle(1, 0, 0, 0, 0);
            guard++;
        end
        chk("arst_reach", 32'(PHASE), 32'b01000);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_phase", 32'(PHASE), 0);
        chk("arst_halted", 32'(HALTED), 1);
        chk("arst_retired", 32'(RETIRED), 0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(1, 0, 0, 0, 0);
        chk("arst_restart", 32'(PHASE), 32'b00001);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
